// File: rtl/bcd_event_counter.sv
// Up/down packed-BCD event counter driven by two debounced push-buttons.
// Step lands SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after a raw rise; no backpressure.
module bcd_event_counter #(
  parameter int NUM_DIGITS      = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter bit SATURATE        = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enable,
  input  logic                    i_error,
  input  logic                    i_inc_in,
  input  logic                    i_dec_in,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_load_value,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_count_pulse,
  output logic                    o_overflow,
  output logic                    o_underflow,
  output logic                    o_at_max,
  output logic                    o_at_zero
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [W-1:0]  LP_MAX  = {NUM_DIGITS{4'h9}};

  logic [1:0] w_raw;
  logic [1:0] w_evt;

  assign w_raw = {i_dec_in, i_inc_in};

  // Index 0 = increment button, index 1 = decrement button.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_evt;
    logic                   w_lvl;

    always_ff @(posedge clk) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign w_lvl = r_sync[SYNC_STAGES-1];
    end else begin : g_deb
      logic [CW-1:0] r_cnt;
      logic          r_lvl;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
        end else if (r_sync[SYNC_STAGES-1] != r_lvl) begin
          if (r_cnt == LP_LAST) begin
            r_lvl <= r_sync[SYNC_STAGES-1];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_lvl = r_lvl;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_prev <= 1'b0;
        r_evt  <= 1'b0;
      end else begin
        r_prev <= w_lvl;
        r_evt  <= w_lvl & ~r_prev;
      end
    end

    assign w_evt[g] = r_evt;
  end

  logic [W-1:0] r_bcd;
  logic         r_pulse;
  logic         r_ovf;
  logic         r_udf;
  logic [W-1:0] w_inc_val;
  logic [W-1:0] w_dec_val;
  logic [W-1:0] w_load_val;
  logic         w_at_max;
  logic         w_at_zero;
  logic         w_inc_step;
  logic         w_dec_step;

  assign w_at_max   = (r_bcd == LP_MAX);
  assign w_at_zero  = (r_bcd == '0);
  // Simultaneous inc and dec events cancel each other.
  assign w_inc_step = w_evt[0] & ~w_evt[1] & i_enable & ~i_error;
  assign w_dec_step = w_evt[1] & ~w_evt[0] & i_enable & ~i_error;

  always_comb begin : p_arith
    logic v_carry;
    logic v_borrow;
    w_inc_val  = r_bcd;
    w_dec_val  = r_bcd;
    w_load_val = '0;
    v_carry    = 1'b1;
    v_borrow   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v_carry) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_inc_val[4*i +: 4] = 4'd0;
        end else begin
          w_inc_val[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          v_carry             = 1'b0;
        end
      end
      if (v_borrow) begin
        if (r_bcd[4*i +: 4] == 4'd0) begin
          w_dec_val[4*i +: 4] = 4'd9;
        end else begin
          w_dec_val[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
          v_borrow            = 1'b0;
        end
      end
      w_load_val[4*i +: 4] = (i_load_value[4*i +: 4] > 4'd9) ? 4'd9 : i_load_value[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcd   <= '0;
      r_pulse <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (i_clear) begin
        r_bcd <= '0;
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else if (i_load) begin
        r_bcd <= w_load_val;
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else if (w_inc_step) begin
        if (w_at_max) r_ovf <= 1'b1;
        if (!(w_at_max && SATURATE)) begin
          r_bcd   <= w_inc_val;
          r_pulse <= 1'b1;
        end
      end else if (w_dec_step) begin
        if (w_at_zero) r_udf <= 1'b1;
        if (!(w_at_zero && SATURATE)) begin
          r_bcd   <= w_dec_val;
          r_pulse <= 1'b1;
        end
      end
    end
  end

  assign o_bcd         = r_bcd;
  assign o_count_pulse = r_pulse;
  assign o_overflow    = r_ovf;
  assign o_underflow   = r_udf;
  assign o_at_max      = w_at_max;
  assign o_at_zero     = w_at_zero;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Bench for bcd_event_counter: wrap and saturate instances share stimulus and are
// checked every cycle against an integer-count model plus literal spot checks.
module tb_bcd_event_counter;

  localparam int ND   = 3;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int L    = S + D;
  localparam int MAXV = 999;

  logic          clk;
  logic          reset;
  logic          i_enable, i_error, i_inc, i_dec, i_clear, i_load;
  logic [4*ND-1:0] i_load_value;

  logic [4*ND-1:0] w_bcd, s_bcd;
  logic w_pul, w_ovf, w_udf, w_max, w_zero;
  logic s_pul, s_ovf, s_udf, s_max, s_zero;

  bcd_event_counter #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_error(i_error),
    .i_inc_in(i_inc), .i_dec_in(i_dec), .i_clear(i_clear), .i_load(i_load),
    .i_load_value(i_load_value), .o_bcd(w_bcd), .o_count_pulse(w_pul),
    .o_overflow(w_ovf), .o_underflow(w_udf), .o_at_max(w_max), .o_at_zero(w_zero));

  bcd_event_counter #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_error(i_error),
    .i_inc_in(i_inc), .i_dec_in(i_dec), .i_clear(i_clear), .i_load(i_load),
    .i_load_value(i_load_value), .o_bcd(s_bcd), .o_count_pulse(s_pul),
    .o_overflow(s_ovf), .o_underflow(s_udf), .o_at_max(s_max), .o_at_zero(s_zero));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid = 1'b0;
  bit hist [2][L];
  bit filt [2];
  bit pend1 [2];
  bit pend2 [2];
  bit ev [2];
  bit raw [2];
  bit allv;
  int cnt_w, cnt_s;
  bit ovf_w, udf_w, pul_w, ovf_s, udf_s, pul_s;
  bit inc_step, dec_step;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int load_to_int(input logic [4*ND-1:0] v);
    int r = 0;
    int m = 1;
    for (int i = 0; i < ND; i++) begin
      int d;
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * m;
      m *= 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    raw[0] = i_inc;
    raw[1] = i_dec;
    if (reset) begin
      m_valid = 1'b1;
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < L; j++) hist[b][j] = 1'b0;
        filt[b] = 0; pend1[b] = 0; pend2[b] = 0;
      end
      cnt_w = 0; cnt_s = 0;
      ovf_w = 0; udf_w = 0; pul_w = 0; ovf_s = 0; udf_s = 0; pul_s = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        ev[b] = pend2[b]; pend2[b] = pend1[b]; pend1[b] = 1'b0;
        for (int j = L - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
        hist[b][0] = raw[b];
        // Level flips once the synced input has disagreed for the last D cycles.
        allv = 1'b1;
        for (int j = S; j < L; j++) if (hist[b][j] == filt[b]) allv = 1'b0;
        if (allv) begin
          pend1[b] = ~filt[b];
          filt[b]  = ~filt[b];
        end
      end
      inc_step = ev[0] && !ev[1] && i_enable && !i_error;
      dec_step = ev[1] && !ev[0] && i_enable && !i_error;
      pul_w = 0; pul_s = 0;
      if (i_clear) begin
        cnt_w = 0; cnt_s = 0; ovf_w = 0; udf_w = 0; ovf_s = 0; udf_s = 0;
      end else if (i_load) begin
        cnt_w = load_to_int(i_load_value); cnt_s = cnt_w;
        ovf_w = 0; udf_w = 0; ovf_s = 0; udf_s = 0;
      end else if (inc_step) begin
        if (cnt_w == MAXV) begin cnt_w = 0; ovf_w = 1; end else cnt_w++;
        pul_w = 1;
        if (cnt_s == MAXV) ovf_s = 1; else begin cnt_s++; pul_s = 1; end
      end else if (dec_step) begin
        if (cnt_w == 0) begin cnt_w = MAXV; udf_w = 1; end else cnt_w--;
        pul_w = 1;
        if (cnt_s == 0) udf_s = 1; else begin cnt_s--; pul_s = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cycle_wrap", {15'd0, w_bcd, w_pul, w_ovf, w_udf, w_max, w_zero},
          {15'd0, to_bcd(cnt_w), pul_w, ovf_w, udf_w, cnt_w == MAXV, cnt_w == 0});
      chk("cycle_sat", {15'd0, s_bcd, s_pul, s_ovf, s_udf, s_max, s_zero},
          {15'd0, to_bcd(cnt_s), pul_s, ovf_s, udf_s, cnt_s == MAXV, cnt_s == 0});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_load(input logic [4*ND-1:0] v);
    i_load = 1'b1; i_load_value = v;
    step(1);
    i_load = 1'b0;
  endtask

  // Press the selected buttons; pulses are sampled right after edge 7.
  task automatic press(input bit [1:0] which, input bit pw, input bit ps, input string nm);
    i_inc = which[0]; i_dec = which[1];
    step(8);
    chk({nm, "_pulse_w"}, w_pul, pw);
    chk({nm, "_pulse_s"}, s_pul, ps);
    step(6);
    i_inc = 1'b0; i_dec = 1'b0;
    step(10);
  endtask

  initial begin
    reset = 1'b1; i_enable = 1'b1; i_error = 1'b0; i_inc = 1'b0; i_dec = 1'b0;
    i_clear = 1'b0; i_load = 1'b0; i_load_value = '0;
    step(3);
    chk("reset_bcd", w_bcd, 12'h000);
    chk("reset_flags", {w_pul, w_ovf, w_udf, w_max, w_zero}, 5'b00001);
    reset = 1'b0;
    step(2);

    // 1: single press, exact latency, release is silent
    i_inc = 1'b1;
    step(7);
    chk("t1_before_edge7", w_bcd, 12'h000);
    step(1);
    chk("t1_edge7_bcd", w_bcd, 12'h001);
    chk("t1_edge7_pulse", w_pul, 1'b1);
    step(1);
    chk("t1_pulse_one_cycle", w_pul, 1'b0);
    step(11);
    i_inc = 1'b0;
    step(12);
    chk("t1_release", w_bcd, 12'h001);

    // 2: bouncing input never qualifies; the final stable level does
    for (int k = 0; k < 3; k++) begin
      i_inc = 1'b1; step(2);
      i_inc = 1'b0; step(2);
    end
    i_inc = 1'b1;
    step(7);
    chk("t2_bounce_ignored", w_bcd, 12'h001);
    step(1);
    chk("t2_stable_step", w_bcd, 12'h002);
    step(10);
    i_inc = 1'b0;
    step(10);

    // 3: carry ripple and overflow
    do_load(12'h099);
    chk("t3_load099", w_bcd, 12'h099);
    press(2'b01, 1'b1, 1'b1, "t3_inc099");
    chk("t3_carry", w_bcd, 12'h100);
    do_load(12'h999);
    press(2'b01, 1'b1, 1'b0, "t3_inc999");
    chk("t3_wrap_bcd", {w_bcd, w_ovf}, {12'h000, 1'b1});
    chk("t3_sat_bcd", {s_bcd, s_ovf}, {12'h999, 1'b1});

    // 4: borrow ripple and underflow
    do_load(12'h100);
    press(2'b10, 1'b1, 1'b1, "t4_dec100");
    chk("t4_borrow", s_bcd, 12'h099);
    do_load(12'h000);
    press(2'b10, 1'b1, 1'b0, "t4_dec000");
    chk("t4_wrap_bcd", {w_bcd, w_udf}, {12'h999, 1'b1});
    chk("t4_sat_bcd", {s_bcd, s_udf}, {12'h000, 1'b1});

    // 5: gating and cancellation
    do_load(12'h005);
    i_enable = 1'b0;
    press(2'b01, 1'b0, 1'b0, "t5_disabled");
    chk("t5_disabled_bcd", w_bcd, 12'h005);
    i_enable = 1'b1; i_error = 1'b1;
    press(2'b01, 1'b0, 1'b0, "t5_error");
    chk("t5_error_bcd", w_bcd, 12'h005);
    i_error = 1'b0;
    press(2'b11, 1'b0, 1'b0, "t5_both");
    chk("t5_both_bcd", w_bcd, 12'h005);
    press(2'b01, 1'b1, 1'b1, "t5_after");
    chk("t5_after_bcd", w_bcd, 12'h006);

    // 6: clear beats load, digit clamp, load drops same-cycle event, reset mid-debounce
    do_load(12'h999);
    press(2'b01, 1'b1, 1'b0, "t6_ovf");
    i_clear = 1'b1; i_load = 1'b1; i_load_value = 12'h123;
    step(1);
    i_clear = 1'b0; i_load = 1'b0;
    chk("t6_clear_wins", {w_bcd, w_ovf, s_bcd, s_ovf}, {12'h000, 1'b0, 12'h000, 1'b0});
    do_load(12'h9A5);
    chk("t6_clamp", s_bcd, 12'h995);
    i_inc = 1'b1;
    step(7);
    i_load = 1'b1; i_load_value = 12'h042;
    step(1);
    i_load = 1'b0;
    step(10);
    i_inc = 1'b0;
    step(10);
    chk("t6_load_drops_evt", w_bcd, 12'h042);
    do_load(12'h999);
    press(2'b01, 1'b1, 1'b0, "t6_pre_reset");
    i_inc = 1'b1;
    step(3);
    reset = 1'b1; i_inc = 1'b0;
    step(2);
    reset = 1'b0;
    step(15);
    chk("t6_reset_abort", {w_bcd, w_ovf, s_bcd, s_ovf}, {12'h000, 1'b0, 12'h000, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_event_counter.md
Name: bcd_event_counter

Overview:
- Parametrised up/down decimal event counter for push-button style inputs.
- Each raw button input is synchronised, debounced and edge-detected internally. Qualified events step a packed BCD count of NUM_DIGITS digits.
- The packed BCD output feeds the display multiplexer/state machine directly.
- Adds over the previous counter: down-counting, width/depth parameters, synchronous load/clear, wrap or saturate mode, status flags.

Parameters:
NUM_DIGITS, 3, number of BCD digits (1..8)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change; 0 = filter bypassed
SYNC_STAGES, 2, flip-flop synchroniser depth per raw input (>=2)
SATURATE, 0, 0 = wrap at limits, 1 = clamp at limits

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  counting permitted when high
error  in  1  counting blocked when high
inc_in  in  1  raw asynchronous increment button
dec_in  in  1  raw asynchronous decrement button
clear  in  1  synchronous clear of count and flags
load  in  1  synchronous load strobe
load_value  in  4*NUM_DIGITS  packed BCD value to load, digit 0 in bits [3:0]
bcd  out  4*NUM_DIGITS  packed BCD count, digit 0 = least significant
count_pulse  out  1  one-cycle strobe when bcd changes due to a step
overflow  out  1  sticky; set on increment at maximum
underflow  out  1  sticky; set on decrement at zero
at_max  out  1  combinational: bcd == all nines
at_zero  out  1  combinational: bcd == 0

Behaviour:
- Reset values: bcd=0, count_pulse=0, overflow=0, underflow=0, all synchroniser and debounce state=0, filtered levels=0.
- A button already held through reset produces exactly one event once it qualifies.
- Filter: each input passes through SYNC_STAGES flops, then a stability counter. The filtered level takes the synced value once that value has differed from the filtered level for DEBOUNCE_CYCLES consecutive cycles. Any mismatch gap restarts the counter.
- An event is the 0->1 transition of the filtered level. Releases never produce events.
- Latency: raw rising level sampled at edge 0 updates bcd at edge SYNC_STAGES+DEBOUNCE_CYCLES+1. count_pulse is high in the cycle following that update edge.
- Priority per cycle: reset > clear > load > step.
- clear: bcd=0, overflow=0, underflow=0.
- load: bcd=load_value, with any digit >9 clamped to 9. Flags are cleared. A same-cycle event is discarded.
- Step occurs only if enable=1 and error=0 in the event cycle. Otherwise the event is dropped, not queued. The debouncers keep running regardless of enable/error.
- inc and dec events in the same cycle cancel: no change, no pulse.
- Increment: ripple BCD carry, with each digit wrapping 9->0 and carrying into the next. At all nines: wrap mode gives 0 and overflow=1; saturate mode holds and sets overflow=1, with no count_pulse.
- Decrement: ripple BCD borrow, with each digit wrapping 0->9. At zero: wrap mode gives all nines and underflow=1; saturate mode holds, sets underflow=1, with no count_pulse.
- Flags are sticky until reset, clear or load.
- bcd digits are always valid BCD (0..9).
- Reset mid-debounce aborts the pending event.

Test Plan:
(NUM_DIGITS=3, DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless noted)
1. From reset, inc_in high 20 cycles then low -> bcd 0x000->0x001 exactly at edge 7 after rise; one count_pulse; release causes no change.
2. inc_in toggles every 2 cycles for 12 cycles, then stays high -> exactly one increment, at stable-level edge +7.
3. load 0x099, inc -> 0x100. load 0x999, inc -> 0x000 with overflow=1 (SATURATE=0). With SATURATE=1 -> stays 0x999, overflow=1, no count_pulse.
4. load 0x100, dec -> 0x099. From 0x000, dec -> 0x999 with underflow=1 (wrap). With SATURATE=1 -> stays 0x000, underflow=1.
5. Qualified inc event with enable=0, then with error=1 -> bcd unchanged both times. inc_in and dec_in driven identically -> no change, no count_pulse.
6. load=1 and clear=1 together -> bcd 0x000, flags 0. load 0x9A5 -> 0x995. reset asserted mid-debounce -> bcd 0, flags 0, no step after reset releases with the input low.
